pi_mem_arb: RTL
===============

PI_MEM_ARB -- requirements
Module: pi_mem_arb

Interface
REQ-001 SHALL have parameter ACC_CYC, default 2, giving the number of clk cycles mem_oe or mem_we is held per access (legal 1..7).
REQ-002 SHALL have port clk, input, 1, the single system clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port pi_act, input, 1, the host strobe from the SPI clock domain (asynchronous to clk).
REQ-005 SHALL have ports pi_oe, pi_we, pi_addr[22:0] and pi_dato[7:0], inputs, giving the host command, address and write data; they are stable while pi_act is high.
REQ-006 SHALL have ports pi_ce_prg, pi_ce_chr and pi_ce_srm, inputs, 1 each, the decoded host region selects.
REQ-007 SHALL have port pi_dati, output, 8, the host read data.
REQ-008 SHALL have ports cart_req (1), cart_we (1), cart_sel[1:0], cart_addr[22:0] and cart_dato[7:0], all inputs, forming the cartridge-side request.
REQ-009 SHALL have port cart_ack, output, 1, a one-cycle pulse that marks cartridge access completion.
REQ-010 SHALL have port cart_dati, output, 8, the cartridge read data, valid from cart_ack onward.
REQ-011 SHALL have ports mem_sel[1:0] (0=PRG, 1=CHR, 2=SRM), mem_addr[22:0], mem_dato[7:0], mem_oe and mem_we, all outputs, forming the shared memory port.
REQ-012 SHALL have port mem_dati, input, 8, the memory read data, valid in the last mem_oe cycle.

Function
REQ-013 SHALL pass pi_act through a 2-flop synchronizer and raise a host request on the synchronized rising edge only.
REQ-014 SHALL drop the host edge if no pi_ce_* is high, and SHALL then start no access.
REQ-015 SHALL otherwise latch pi_we, pi_addr, pi_dato and the region into a one-entry host-pending slot in the edge cycle.
REQ-016 SHALL overwrite an occupied host slot on a new host edge (last wins) and SHALL set sticky status bit host_ovf, which is observable in simulation only.
REQ-017 SHALL run FSM IDLE -> GRANT -> ACCESS -> DONE -> IDLE.
REQ-018 IDLE: SHALL go to GRANT when host pending or cart_req is high; otherwise stays IDLE.
REQ-019 GRANT: SHALL select the winner; a single requester wins; if both request, the one not served last wins (round-robin); SHALL drive mem_sel, mem_addr and mem_dato from the winner; strobes stay low.
REQ-020 ACCESS: SHALL hold mem_oe (read) or mem_we (write) high for exactly ACC_CYC cycles, with address and data stable throughout.
REQ-021 SHALL capture mem_dati in the last ACCESS cycle.
REQ-022 DONE: SHALL deassert strobes; a host read loads pi_dati; a cart read loads cart_dati; a cart access pulses cart_ack; the host slot is cleared; the last-served pointer is updated.
REQ-023 SHALL give a lone host request a latency from synchronized edge to pi_dati valid of 3+ACC_CYC clk cycles.
REQ-024 SHALL give a worst-case host latency, when blocked by one cart access, of 6+2*ACC_CYC clk cycles.
REQ-025 SHALL register pi_dati and cart_dati and hold them until the next read of the same requester.
REQ-026 SHALL not accept a new cart request until the cycle after cart_ack; cart_req must stay high until cart_ack.
REQ-027 SHALL latch a host edge arriving in GRANT, ACCESS or DONE into the slot and serve it after IDLE.
REQ-028 SHALL decrement the ACCESS counter modulo-free, with no wrap.
REQ-029 SHALL fault nothing for ACC_CYC=1: ACCESS lasts exactly one cycle.

Reset
REQ-030 SHALL, while rst_n is low, force the FSM to IDLE, all outputs to 0, the host slot and host_ovf to cleared, the synchronizer to 0 and the last-served pointer to HOST, so cart wins the first tie.
REQ-031 SHALL, on reset mid-ACCESS, drop strobes asynchronously and abandon the access with no ack.

Structure
REQ-032 SHALL put the FSM state enum, the region encoding (SEL_PRG/CHR/SRM) and the requester id enum in the shared package.
REQ-033 SHALL implement the synchronizer plus edge detector as sub-module pi_act_sync.

Verification
REQ-034 SHALL cover a lone host write: pi_ce_prg, pi_addr=0x000123 and pi_dato=0x5A with ACC_CYC=2 -> mem_we high for 2 cycles, mem_sel=0 and mem_addr=0x000123.
REQ-035 SHALL cover a host read: pi_ce_chr with mem_dati=0xC3 -> pi_dati=0xC3 at edge+5 cycles, with cart_ack staying 0.
REQ-036 SHALL cover a simultaneous request from both sides after reset -> cart served first, then host; repeating this -> host served first.
REQ-037 SHALL cover a host edge with no pi_ce_* set -> no mem strobe and the FSM stays IDLE.
REQ-038 SHALL cover rst_n low during ACCESS -> mem_we=0 immediately, with no cart_ack and all outputs 0.
REQ-039 SHALL cover two host edges before service -> only the second address is accessed, and host_ovf=1.

Source files
------------

// File: rtl/pi_mem_arb_pkg.sv
// Shared types for the host/cartridge memory arbiter: FSM states,
// memory region encoding, requester identities and the host command slot.
package pi_mem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // Memory region encoding as seen on mem_sel.
  localparam logic [1:0] SEL_PRG = 2'd0;
  localparam logic [1:0] SEL_CHR = 2'd1;
  localparam logic [1:0] SEL_SRM = 2'd2;

  // Who owns (or last owned) the shared memory port.
  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CART = 1'b1
  } req_id_e;

  // One buffered host command.
  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [22:0] addr;
    logic [7:0]  dato;
  } host_cmd_t;

  // Collapse the one-hot host region selects into mem_sel encoding.
  // PRG has priority over CHR, CHR over SRM, should more than one be set.
  function automatic logic [1:0] region_from_ce(input logic ce_prg,
                                                input logic ce_chr,
                                                input logic ce_srm);
    logic [1:0] sel;
    sel = SEL_SRM;
    if (ce_prg) begin
      sel = SEL_PRG;
    end else if (ce_chr) begin
      sel = SEL_CHR;
    end else if (ce_srm) begin
      sel = SEL_SRM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pi_mem_arb_pi_act_sync.sv
// Brings the host strobe from the SPI clock domain into clk and turns its
// synchronized rising edge into a single-cycle pulse.
module pi_act_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pi_act,
  output logic act_rise
);

  logic sync_meta;
  logic sync_q;
  logic sync_prev;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= pi_act;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  assign act_rise = sync_q & ~sync_prev;

endmodule

// File: rtl/pi_mem_arb.sv
// Arbitrates one shared memory port between the SPI host and the cartridge
// bus. Host commands are buffered in a one-entry slot; contention is resolved
// round-robin and every access takes a fixed ACC_CYC strobe cycles.
module pi_mem_arb
  import pi_mem_arb_pkg::*;
#(
  parameter int ACC_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pi_act,
  input  logic        pi_oe,
  input  logic        pi_we,
  input  logic [22:0] pi_addr,
  input  logic [7:0]  pi_dato,
  input  logic        pi_ce_prg,
  input  logic        pi_ce_chr,
  input  logic        pi_ce_srm,
  output logic [7:0]  pi_dati,
  input  logic        cart_req,
  input  logic        cart_we,
  input  logic [1:0]  cart_sel,
  input  logic [22:0] cart_addr,
  input  logic [7:0]  cart_dato,
  output logic        cart_ack,
  output logic [7:0]  cart_dati,
  output logic [1:0]  mem_sel,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_dato,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_dati
);

  localparam logic [2:0] CNT_LOAD = 3'(ACC_CYC - 1);

  arb_state_e  state_q;
  arb_state_e  state_d;
  req_id_e     winner;
  req_id_e     cur_q;
  req_id_e     last_q;

  logic        act_rise;
  logic        host_edge;
  host_cmd_t   host_new;
  host_cmd_t   host_slot_q;
  logic        host_pend_q;
  logic        host_inserv_q;
  logic        host_reedge_q;
  logic        host_claim;
  logic        host_unserved;
  logic        host_ovf;
  logic        cart_req_ok;

  logic [2:0]  cnt_q;
  logic        g_we_q;
  logic [1:0]  g_sel_q;
  logic [22:0] g_addr_q;
  logic [7:0]  g_dato_q;
  logic [7:0]  rd_q;

  logic [1:0]  win_sel;
  logic [22:0] win_addr;
  logic [7:0]  win_dato;
  logic        win_we;

  pi_act_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi_act   (pi_act),
    .act_rise (act_rise)
  );

  // A host edge only counts when it targets a region. A command that claims
  // both oe and we is treated as a read so it cannot corrupt memory.
  assign host_edge     = act_rise & (pi_ce_prg | pi_ce_chr | pi_ce_srm);
  assign host_new.we   = pi_we & ~pi_oe;
  assign host_new.sel  = region_from_ce(pi_ce_prg, pi_ce_chr, pi_ce_srm);
  assign host_new.addr = pi_addr;
  assign host_new.dato = pi_dato;

  // The cart still holds cart_req in the cycle cart_ack is high, so that
  // cycle must not be mistaken for a fresh request.
  assign cart_req_ok = cart_req & ~cart_ack;

  // The host slot is being handed to the memory port this cycle.
  assign host_claim = (state_q == ST_GRANT) && (winner == REQ_HOST);

  // The slot holds a command nobody has started on; overwriting it loses it.
  assign host_unserved = host_pend_q && !host_claim &&
                         !(host_inserv_q && !host_reedge_q);

  // Pick the requester to serve: a lone requester wins, a tie goes to the
  // side that was not served last.
  always_comb begin
    winner = REQ_CART;
    if (host_pend_q && cart_req_ok) begin
      winner = (last_q == REQ_HOST) ? REQ_CART : REQ_HOST;
    end else if (host_pend_q) begin
      winner = REQ_HOST;
    end
  end

  // Command fields of the current winner.
  always_comb begin
    win_we   = cart_we;
    win_sel  = cart_sel;
    win_addr = cart_addr;
    win_dato = cart_dato;
    if (winner == REQ_HOST) begin
      win_we   = host_slot_q.we;
      win_sel  = host_slot_q.sel;
      win_addr = host_slot_q.addr;
      win_dato = host_slot_q.dato;
    end
  end

  // Host slot bookkeeping: capture edges, flag overwrites, release on DONE
  // unless another edge arrived while the previous command was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_slot_q   <= '0;
      host_pend_q   <= 1'b0;
      host_inserv_q <= 1'b0;
      host_reedge_q <= 1'b0;
      host_ovf      <= 1'b0;
    end else begin
      if (host_edge) begin
        host_slot_q <= host_new;
        host_pend_q <= 1'b1;
        if (host_unserved) begin
          host_ovf <= 1'b1;
        end
        if (host_inserv_q || host_claim) begin
          host_reedge_q <= 1'b1;
        end
      end
      if (host_claim) begin
        host_inserv_q <= 1'b1;
      end
      if ((state_q == ST_DONE) && (cur_q == REQ_HOST)) begin
        host_pend_q   <= host_reedge_q | host_edge;
        host_inserv_q <= 1'b0;
        host_reedge_q <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a host edge in IDLE starts arbitration right away so
  // the slot is already filled when GRANT evaluates it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (host_pend_q || host_edge || cart_req_ok) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the winning command, time the strobe and hand back results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= REQ_HOST;
      last_q    <= REQ_HOST;
      cnt_q     <= 3'd0;
      g_we_q    <= 1'b0;
      g_sel_q   <= 2'd0;
      g_addr_q  <= 23'd0;
      g_dato_q  <= 8'd0;
      rd_q      <= 8'd0;
      pi_dati   <= 8'd0;
      cart_dati <= 8'd0;
      cart_ack  <= 1'b0;
    end else begin
      cart_ack <= 1'b0;
      case (state_q)
        ST_GRANT: begin
          cur_q    <= winner;
          g_we_q   <= win_we;
          g_sel_q  <= win_sel;
          g_addr_q <= win_addr;
          g_dato_q <= win_dato;
          cnt_q    <= CNT_LOAD;
        end
        ST_ACCESS: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            rd_q <= mem_dati;
          end
        end
        ST_DONE: begin
          last_q <= cur_q;
          if (cur_q == REQ_HOST) begin
            if (!g_we_q) begin
              pi_dati <= rd_q;
            end
          end else begin
            cart_ack <= 1'b1;
            if (!g_we_q) begin
              cart_dati <= rd_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shared memory port: the winner is presented in GRANT, the latched command
  // through ACCESS and DONE, and strobes only while in ACCESS.
  always_comb begin
    mem_sel  = 2'd0;
    mem_addr = 23'd0;
    mem_dato = 8'd0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_GRANT: begin
        mem_sel  = win_sel;
        mem_addr = win_addr;
        mem_dato = win_dato;
      end
      ST_ACCESS: begin
        mem_sel  = g_sel_q;
        mem_addr = g_addr_q;
        mem_dato = g_dato_q;
        mem_oe   = ~g_we_q;
        mem_we   = g_we_q;
      end
      ST_DONE: begin
        mem_sel  = g_sel_q;
        mem_addr = g_addr_q;
        mem_dato = g_dato_q;
      end
      default: begin
      end
    endcase
  end

endmodule
